// File: rtl/amr_wdt_pkg.sv
// Shared types and default constants for the watchdog feed path.
// Used by heartbeat_kicker and its helpers.
package amr_wdt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        KICK    = 2'd2,
        HOLDOFF = 2'd3
    } hb_state_t;

    localparam int HB_WINDOW_DEF   = 1000;
    localparam int HB_PULSE_W_DEF  = 2;
    localparam int HB_HOLDOFF_DEF  = 16;
    localparam int HB_MAX_MISS_DEF = 3;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/amr_rise_detect.sv
// One-flop rising-edge detector; rise is combinational and high for the
// cycle in which din is 1 but was 0 at the previous edge.
module amr_rise_detect (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic rise
);

    logic din_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            din_reg <= 1'b0;
        end else begin
            din_reg <= din;
        end
    end

    assign rise = din & ~din_reg;

endmodule

// File: rtl/heartbeat_kicker.sv
// Gates the watchdog heartbeat on all liveness sources checking in within a
// window, tracks consecutive missed windows, and converts force_req into pulses.
module heartbeat_kicker
    import amr_wdt_pkg::*;
#(
    parameter int NUM_SRC  = 4,
    parameter int WINDOW   = HB_WINDOW_DEF,
    parameter int PULSE_W  = HB_PULSE_W_DEF,
    parameter int HOLDOFF  = HB_HOLDOFF_DEF,
    parameter int MAX_MISS = HB_MAX_MISS_DEF
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          enable,
    input  logic [NUM_SRC-1:0]            alive,
    input  logic                          force_req,
    output logic                          heartbeat,
    output logic                          force_reset,
    output logic                          stall,
    output logic [NUM_SRC-1:0]            stall_mask,
    output logic [$clog2(MAX_MISS+1)-1:0] miss_count
);

    localparam int WW = $clog2(WINDOW);
    localparam int PW = cnt_width(PULSE_W);
    localparam int HW = cnt_width(HOLDOFF);
    localparam int MW = $clog2(MAX_MISS + 1);

    localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);
    localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_W - 1);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLDOFF - 1);
    localparam logic [MW-1:0] MISS_MAX   = MW'(MAX_MISS);

    hb_state_t            state_reg, state_next;
    logic [NUM_SRC-1:0]   seen_reg, seen_next;
    logic [WW-1:0]        win_cnt_reg, win_cnt_next;
    logic [PW-1:0]        pulse_cnt_reg, pulse_cnt_next;
    logic [HW-1:0]        hold_cnt_reg, hold_cnt_next;
    logic                 heartbeat_reg, heartbeat_next;
    logic                 force_reset_reg;
    logic                 stall_reg, stall_next;
    logic [NUM_SRC-1:0]   stall_mask_reg, stall_mask_next;
    logic [MW-1:0]        miss_count_reg, miss_count_next;

    logic [NUM_SRC-1:0]   seen_all;
    logic                 win_done, win_expire, pulse_done, hold_done;
    logic [MW-1:0]        miss_inc;
    logic                 force_rise;

    amr_rise_detect u_force_rise (
        .clk  (clk),
        .rstn (rstn),
        .din  (force_req),
        .rise (force_rise)
    );

    // Current-cycle check-ins count, so a source arriving on the last cycle still completes the window.
    assign seen_all   = seen_reg | alive;
    assign win_done   = &seen_all;
    assign win_expire = (win_cnt_reg == WIN_LAST);
    assign pulse_done = (pulse_cnt_reg == '0);
    assign hold_done  = (hold_cnt_reg == '0);
    assign miss_inc   = (miss_count_reg == MISS_MAX) ? miss_count_reg : miss_count_reg + MW'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg       <= IDLE;
            seen_reg        <= '0;
            win_cnt_reg     <= '0;
            pulse_cnt_reg   <= '0;
            hold_cnt_reg    <= '0;
            heartbeat_reg   <= 1'b0;
            force_reset_reg <= 1'b0;
            stall_reg       <= 1'b0;
            stall_mask_reg  <= '0;
            miss_count_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            seen_reg        <= seen_next;
            win_cnt_reg     <= win_cnt_next;
            pulse_cnt_reg   <= pulse_cnt_next;
            hold_cnt_reg    <= hold_cnt_next;
            heartbeat_reg   <= heartbeat_next;
            force_reset_reg <= force_rise;
            stall_reg       <= stall_next;
            stall_mask_reg  <= stall_mask_next;
            miss_count_reg  <= miss_count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:                 state_next = COLLECT;
                COLLECT:              if (win_done)   state_next = KICK;
                KICK:                 if (pulse_done) state_next = amr_wdt_pkg::HOLDOFF;
                amr_wdt_pkg::HOLDOFF: if (hold_done)  state_next = COLLECT;
                default:              state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        seen_next       = seen_reg;
        win_cnt_next    = win_cnt_reg;
        pulse_cnt_next  = pulse_cnt_reg;
        hold_cnt_next   = hold_cnt_reg;
        heartbeat_next  = heartbeat_reg;
        stall_next      = stall_reg;
        stall_mask_next = stall_mask_reg;
        miss_count_next = miss_count_reg;
        if (!enable || state_reg == IDLE) begin
            seen_next       = '0;
            win_cnt_next    = '0;
            pulse_cnt_next  = '0;
            hold_cnt_next   = '0;
            heartbeat_next  = 1'b0;
            stall_next      = 1'b0;
            stall_mask_next = '0;
            miss_count_next = '0;
        end else begin
            case (state_reg)
                COLLECT: begin
                    if (win_done) begin
                        heartbeat_next  = 1'b1;
                        seen_next       = '0;
                        win_cnt_next    = '0;
                        pulse_cnt_next  = PULSE_LOAD;
                        stall_next      = 1'b0;
                        stall_mask_next = '0;
                        miss_count_next = '0;
                    end else if (win_expire) begin
                        miss_count_next = miss_inc;
                        stall_next      = stall_reg | (miss_inc == MISS_MAX);
                        stall_mask_next = ~seen_all;
                        seen_next       = '0;
                        win_cnt_next    = '0;
                    end else begin
                        seen_next    = seen_all;
                        win_cnt_next = win_cnt_reg + WW'(1);
                    end
                end
                KICK: begin
                    seen_next = seen_all;
                    if (pulse_done) begin
                        heartbeat_next = 1'b0;
                        hold_cnt_next  = HOLD_LOAD;
                    end else begin
                        pulse_cnt_next = pulse_cnt_reg - PW'(1);
                    end
                end
                amr_wdt_pkg::HOLDOFF: begin
                    seen_next = seen_all;
                    if (hold_done) begin
                        win_cnt_next = '0;
                    end else begin
                        hold_cnt_next = hold_cnt_reg - HW'(1);
                    end
                end
                default: begin
                    heartbeat_next = 1'b0;
                end
            endcase
        end
    end

    assign heartbeat   = heartbeat_reg;
    assign force_reset = force_reset_reg;
    assign stall       = stall_reg;
    assign stall_mask  = stall_mask_reg;
    assign miss_count  = miss_count_reg;

endmodule
